// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Shares the single ParkingFSM and its door between NUM_LANES entry lanes and
// one exit lane. One request is served per transaction. The winner gets a
// one-cycle sensor pulse into the FSM. The gate then stays busy for
// DOOR_CYCLES cycles before the next request is looked at. Requests that the
// FSM cannot honour (lot full, or exit from an empty slot) are rejected with a
// one-cycle pulse and the gate stays idle.
//
// Build option (macro EXIT_PRIORITY_EN):
//   defined   : exit_req always beats the entry lanes.
//   undefined : exit takes part in the round-robin as virtual lane NUM_LANES.
//               Exit grants and exit rejects also advance the pointer.
//
// Ports:
//   clk_i            system clock, rising edge
//   reset_i          asynchronous, active-high reset
//   entry_req_i      level request per entry lane
//   exit_req_i       level exit request
//   exit_slot_i      slot of the departing car, valid with exit_req_i
//   full_light_i     lot full, from the ParkingFSM
//   slot_map_i       slot occupancy from the ParkingFSM (bit i = slot i taken)
//   entry_sensor_o   one-cycle entry pulse to the ParkingFSM
//   exit_sensor_o    one-cycle exit pulse to the ParkingFSM
//   exit_location_o  slot index with exit_sensor_o, else 0
//   entry_grant_o    one-hot grant, coincident with entry_sensor_o
//   exit_grant_o     exit grant, coincident with exit_sensor_o
//   entry_reject_o   one-hot reject (lot full)
//   exit_reject_o    exit reject (slot not occupied)
//   gate_busy_o      high while in ISSUE or HOLD
//   arb_state_o      IDLE=0, ISSUE=1, HOLD=2
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module parking_gate_arbiter #(
    parameter int NUM_LANES   = 2,
    parameter int DOOR_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_LANES-1:0] entry_req_i,
    input  logic                 exit_req_i,
    input  logic [1:0]           exit_slot_i,
    input  logic                 full_light_i,
    input  logic [3:0]           slot_map_i,
    output logic                 entry_sensor_o,
    output logic                 exit_sensor_o,
    output logic [1:0]           exit_location_o,
    output logic [NUM_LANES-1:0] entry_grant_o,
    output logic                 exit_grant_o,
    output logic [NUM_LANES-1:0] entry_reject_o,
    output logic                 exit_reject_o,
    output logic                 gate_busy_o,
    output logic [1:0]           arb_state_o
);

    // Pointer width covers the exit as virtual lane NUM_LANES in either build.
    localparam int PTR_W = $clog2(NUM_LANES + 1);
`ifdef EXIT_PRIORITY_EN
    localparam int RING      = NUM_LANES;
    localparam bit EXIT_PRIO = 1'b1;
`else
    localparam int RING      = NUM_LANES + 1;
    localparam bit EXIT_PRIO = 1'b0;
`endif
    localparam logic [PTR_W-1:0] EXIT_IDX = PTR_W'(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 entry_sensor_q, entry_sensor_d;
    logic                 exit_sensor_q, exit_sensor_d;
    logic [1:0]           exit_location_q, exit_location_d;
    logic [NUM_LANES-1:0] entry_grant_q, entry_grant_d;
    logic                 exit_grant_q, exit_grant_d;
    logic [NUM_LANES-1:0] entry_reject_q, entry_reject_d;
    logic                 exit_reject_q, exit_reject_d;
    logic                 gate_busy_q, gate_busy_d;

    logic [NUM_LANES:0]   req_all_s;
    logic [PTR_W-1:0]     idx_s;
    logic [PTR_W-1:0]     win_s;
    logic                 found_s;
    logic [PTR_W-1:0]     ptr_next_s;
    logic [NUM_LANES-1:0] lane_onehot_s;

    // Winner search: first request at or after the pointer, wrapping round the ring.
    always_comb begin
        req_all_s = {exit_req_i, entry_req_i};
        idx_s     = '0;
        win_s     = '0;
        found_s   = 1'b0;
        // Scan from the far end so the position closest to the pointer wins.
        for (int k = RING - 1; k >= 0; k--) begin
            idx_s   = PTR_W'((int'(ptr_q) + k) % RING);
            win_s   = req_all_s[idx_s] ? idx_s : win_s;
            found_s = found_s | req_all_s[idx_s];
        end
        // With exit priority the exit is outside the ring and simply overrides it.
        if (EXIT_PRIO && exit_req_i) begin
            win_s   = EXIT_IDX;
            found_s = 1'b1;
        end else begin
            win_s   = win_s;
            found_s = found_s;
        end
        ptr_next_s    = PTR_W'((int'(win_s) + 1) % RING);
        lane_onehot_s = {{(NUM_LANES-1){1'b0}}, 1'b1} << win_s;
    end

    // Next-state and next-output logic of the gate FSM.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        entry_sensor_d  = 1'b0;
        exit_sensor_d   = 1'b0;
        exit_location_d = 2'b00;
        entry_grant_d   = '0;
        exit_grant_d    = 1'b0;
        entry_reject_d  = '0;
        exit_reject_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!found_s) begin
                    state_d = IDLE;
                end else if (win_s == EXIT_IDX) begin
                    // Exit only moves the pointer when it is part of the ring.
                    ptr_d = EXIT_PRIO ? ptr_q : ptr_next_s;
                    if (slot_map_i[exit_slot_i]) begin
                        state_d         = ISSUE;
                        exit_sensor_d   = 1'b1;
                        exit_grant_d    = 1'b1;
                        exit_location_d = exit_slot_i;
                    end else begin
                        exit_reject_d = 1'b1;
                    end
                end else begin
                    // The pointer moves past the served lane whether it is granted or rejected.
                    ptr_d = ptr_next_s;
                    if (full_light_i) begin
                        entry_reject_d = lane_onehot_s;
                    end else begin
                        state_d        = ISSUE;
                        entry_sensor_d = 1'b1;
                        entry_grant_d  = lane_onehot_s;
                    end
                end
            end
            ISSUE: begin
                state_d = HOLD;
                cnt_d   = CNT_W'(DOOR_CYCLES - 1);
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        gate_busy_d = (state_d != IDLE);
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            entry_sensor_q  <= 1'b0;
            exit_sensor_q   <= 1'b0;
            exit_location_q <= 2'b00;
            entry_grant_q   <= '0;
            exit_grant_q    <= 1'b0;
            entry_reject_q  <= '0;
            exit_reject_q   <= 1'b0;
            gate_busy_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            entry_sensor_q  <= entry_sensor_d;
            exit_sensor_q   <= exit_sensor_d;
            exit_location_q <= exit_location_d;
            entry_grant_q   <= entry_grant_d;
            exit_grant_q    <= exit_grant_d;
            entry_reject_q  <= entry_reject_d;
            exit_reject_q   <= exit_reject_d;
            gate_busy_q     <= gate_busy_d;
        end
    end

    assign entry_sensor_o  = entry_sensor_q;
    assign exit_sensor_o   = exit_sensor_q;
    assign exit_location_o = exit_location_q;
    assign entry_grant_o   = entry_grant_q;
    assign exit_grant_o    = exit_grant_q;
    assign entry_reject_o  = entry_reject_q;
    assign exit_reject_o   = exit_reject_q;
    assign gate_busy_o     = gate_busy_q;
    assign arb_state_o     = state_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for parking_gate_arbiter.
// The reference model works at the transaction level. It tracks the
// round-robin pointer, the cycle at which the gate becomes free again and the
// cycle of the last sensor pulse. The expected state and outputs for each
// cycle come from those numbers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parking_gate_arbiter;

    localparam int NL = 2;
    localparam int D  = 4;
    localparam int CW = 3;
`ifdef EXIT_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NL-1:0] entry_req;
    logic          exit_req;
    logic [1:0]    exit_slot;
    logic          full_light;
    logic [3:0]    slot_map;
    logic          entry_sensor, exit_sensor, exit_grant, exit_reject, gate_busy;
    logic [1:0]    exit_location, arb_state;
    logic [NL-1:0] entry_grant, entry_reject;

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cyc;
    int            m_ptr;
    int            idle_from;
    int            pulse_cyc;
    bit            auto_drop;
    logic [NL-1:0] drop_ent;
    bit            drop_exit;

    parking_gate_arbiter #(.NUM_LANES(NL), .DOOR_CYCLES(D), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(rst),
        .entry_req_i(entry_req), .exit_req_i(exit_req), .exit_slot_i(exit_slot),
        .full_light_i(full_light), .slot_map_i(slot_map),
        .entry_sensor_o(entry_sensor), .exit_sensor_o(exit_sensor),
        .exit_location_o(exit_location), .entry_grant_o(entry_grant),
        .exit_grant_o(exit_grant), .entry_reject_o(entry_reject),
        .exit_reject_o(exit_reject), .gate_busy_o(gate_busy), .arb_state_o(arb_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic es, input logic xs, input logic [1:0] xl,
                                         input logic [NL-1:0] eg, input logic xg,
                                         input logic [NL-1:0] er, input logic xr,
                                         input logic gb, input logic [1:0] st);
        return 32'({es, xs, xl, eg, xg, er, xr, gb, st});
    endfunction

    function automatic logic [31:0] obs();
        return pack(entry_sensor, exit_sensor, exit_location, entry_grant, exit_grant,
                    entry_reject, exit_reject, gate_busy, arb_state);
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs after the next edge for the inputs presented in cycle cyc.
    task automatic predict(output logic [31:0] expv);
        logic          es, xs, xg, xr, gb;
        logic [1:0]    xl, st;
        logic [NL-1:0] eg, er;
        int            w, ring, j;
        es = 1'b0; xs = 1'b0; xg = 1'b0; xr = 1'b0; xl = 2'd0;
        eg = '0; er = '0;
        w = -1;
        ring = PRIO ? NL : NL + 1;
        drop_ent = '0;
        drop_exit = 1'b0;
        if (cyc >= idle_from) begin
            if (PRIO && exit_req) begin
                w = NL;
            end else begin
                for (int k = 0; k < ring; k++) begin
                    j = (m_ptr + k) % ring;
                    if (w < 0 && ((j == NL) ? exit_req : entry_req[j])) w = j;
                end
            end
            if (w == NL) begin
                if (!PRIO) m_ptr = (NL + 1) % ring;
                if (slot_map[exit_slot]) begin
                    xs = 1'b1; xg = 1'b1; xl = exit_slot;
                    pulse_cyc = cyc + 1;
                    idle_from = cyc + D + 2;
                end else begin
                    xr = 1'b1;
                end
                drop_exit = 1'b1;
            end else if (w >= 0) begin
                m_ptr = (w + 1) % ring;
                if (full_light) begin
                    er[w] = 1'b1;
                end else begin
                    es = 1'b1; eg[w] = 1'b1;
                    pulse_cyc = cyc + 1;
                    idle_from = cyc + D + 2;
                end
                drop_ent[w] = 1'b1;
            end
        end
        st = (cyc + 1 == pulse_cyc) ? 2'd1 : ((cyc + 1 < idle_from) ? 2'd2 : 2'd0);
        gb = (st != 2'd0);
        expv = pack(es, xs, xl, eg, xg, er, xr, gb, st);
    endtask

    // One clock: predict, clock, compare, then let requesters drop served requests.
    task automatic step();
        logic [31:0] e;
        predict(e);
        @(posedge clk);
        #1;
        cyc++;
        chk($sformatf("outs@%0d", cyc), obs(), e);
        if (auto_drop) begin
            entry_req = entry_req & ~drop_ent;
            if (drop_exit) exit_req = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_async", obs(), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold", obs(), 32'd0);
        rst = 1'b0;
        cyc++;
        m_ptr = 0;
        idle_from = cyc;
        pulse_cyc = -10;
    endtask

    initial begin
        entry_req = '0; exit_req = 1'b0; exit_slot = 2'd0;
        full_light = 1'b0; slot_map = 4'd0;
        auto_drop = 1'b1; cyc = 0; m_ptr = 0; idle_from = 0; pulse_cyc = -10;
        #2;
        apply_reset();

        // Round-robin with both lanes held.
        auto_drop = 1'b0;
        entry_req = 2'b11;
        step();
        chk("rr_first_grant", 32'(entry_grant), 32'd1);
        steps(12);
        entry_req = 2'b00;
        auto_drop = 1'b1;
        steps(D + 2);

        // Lot full: entry rejected, gate stays idle.
        full_light = 1'b1;
        entry_req = 2'b01;
        step();
        chk("full_reject", 32'(entry_reject), 32'd1);
        chk("full_state", 32'(arb_state), 32'd0);
        steps(2);

        // Exit from an occupied slot, then from an empty one.
        full_light = 1'b0;
        slot_map = 4'b0100;
        exit_req = 1'b1;
        exit_slot = 2'd2;
        step();
        chk("exit_loc", 32'(exit_location), 32'd2);
        steps(D + 1);
        exit_req = 1'b1;
        exit_slot = 2'd1;
        step();
        chk("exit_reject", 32'(exit_reject), 32'd1);
        chk("exit_no_sensor", 32'(exit_sensor), 32'd0);
        steps(2);

        // Exit and entry together on a full lot, pointer at 0.
        apply_reset();
        slot_map = 4'b1111;
        full_light = 1'b1;
        exit_req = 1'b1;
        exit_slot = 2'd0;
        entry_req = 2'b01;
        step();
        full_light = 1'b0;
        steps(2 * D + 6);
        entry_req = 2'b11;
        steps(D + 3);
        entry_req = 2'b00;
        steps(D + 2);

        // Reset during the second HOLD cycle.
        entry_req = 2'b01;
        steps(3);
        chk("hold_state", 32'(arb_state), 32'd2);
        apply_reset();
        entry_req = 2'b11;
        step();
        chk("post_rst_lane0", 32'(entry_grant), 32'd1);
        entry_req = 2'b00;
        steps(D + 2);

        // Randomized traffic.
        auto_drop = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int l = 0; l < NL; l++) begin
                if (!entry_req[l] && $urandom_range(3) == 0) entry_req[l] = 1'b1;
            end
            if (!exit_req && $urandom_range(4) == 0) begin
                exit_req = 1'b1;
                exit_slot = 2'($urandom_range(3));
            end
            full_light = ($urandom_range(2) == 0);
            slot_map = 4'($urandom_range(15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
